// File: rtl/mc_ctrl_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_hs_if
// Brief    : IR/flag inputs, memory handshake and datapath controls of mc_ctrl_hs.
// Revision : 1.0
// ============================================================================
interface mc_ctrl_hs_if #(
    parameter int ALUOP_W = 4
);
    logic               zero;
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               mem_ready;

    logic               mem_req;
    logic               reg_write;
    logic               mem_write;
    logic               pc_write;
    logic               ir_write;
    logic               ext_op;
    logic               iord;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [1:0]         gpr_sel;
    logic [1:0]         wd_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic               trap;
    logic [1:0]         trap_code;
    logic [2:0]         state_o;

    // Controller side
    modport master (
        input  zero, op, funct, mem_ready,
        output mem_req, reg_write, mem_write, pc_write, ir_write, ext_op, iord,
        output alu_src_a, alu_src_b, pc_source, gpr_sel, wd_sel, alu_op,
        output trap, trap_code, state_o
    );

    // Datapath / memory side
    modport slave (
        output zero, op, funct, mem_ready,
        input  mem_req, reg_write, mem_write, pc_write, ir_write, ext_op, iord,
        input  alu_src_a, alu_src_b, pc_source, gpr_sel, wd_sel, alu_op,
        input  trap, trap_code, state_o
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_hs
// Brief    : Multicycle MIPS control FSM with memory handshake, watchdog and
//            illegal-instruction trap. MC_CTRL_PERF_EN adds cyc_cnt/inst_cnt.
// Revision : 1.0
// ============================================================================
module mc_ctrl_hs #(
    parameter int ALUOP_W = 4,
    parameter int TMO_CYC = 16
`ifdef MC_CTRL_PERF_EN
    ,
    parameter int CNT_W   = 32
`endif
) (
    input  wire             clk,
    input  wire             rst,
    mc_ctrl_hs_if.master    bus
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] inst_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_F_SLL    = 6'h00;
    localparam logic [5:0] c_F_SRL    = 6'h02;
    localparam logic [5:0] c_F_SLLV   = 6'h04;
    localparam logic [5:0] c_F_SRLV   = 6'h06;
    localparam logic [5:0] c_F_JR     = 6'h08;
    localparam logic [5:0] c_F_ADD    = 6'h20;
    localparam logic [5:0] c_F_ADDU   = 6'h21;
    localparam logic [5:0] c_F_SUB    = 6'h22;
    localparam logic [5:0] c_F_SUBU   = 6'h23;
    localparam logic [5:0] c_F_AND    = 6'h24;
    localparam logic [5:0] c_F_OR     = 6'h25;
    localparam logic [5:0] c_F_NOR    = 6'h27;
    localparam logic [5:0] c_F_SLT    = 6'h2A;
    localparam logic [5:0] c_F_SLTU   = 6'h2B;

    localparam logic [3:0] c_ALU_ADD  = 4'd1;
    localparam logic [3:0] c_ALU_SUB  = 4'd2;
    localparam logic [3:0] c_ALU_AND  = 4'd3;
    localparam logic [3:0] c_ALU_OR   = 4'd4;
    localparam logic [3:0] c_ALU_SLT  = 4'd5;
    localparam logic [3:0] c_ALU_SLTU = 4'd6;
    localparam logic [3:0] c_ALU_SLL  = 4'd7;
    localparam logic [3:0] c_ALU_SRL  = 4'd8;
    localparam logic [3:0] c_ALU_NOR  = 4'd9;
    localparam logic [3:0] c_ALU_LUI  = 4'd10;

    localparam logic [1:0] c_TRAP_ILL = 2'b01;
    localparam logic [1:0] c_TRAP_TMO = 2'b10;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] w_trap_code_nxt;
    logic       r_trap;
    logic [1:0] r_trap_code;
    logic       w_tmo_hit;

    logic       w_valid;
    logic       w_shamt;
    logic       w_itype_alu;
    logic       w_ext_zero;
    logic       w_is_jr;
    logic       w_is_lw;
    logic       w_is_sw;
    logic [3:0] w_alu_code;

    logic       w_mem_req;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_ext_op;
    logic       w_iord;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_source;
    logic [1:0] w_gpr_sel;
    logic [1:0] w_wd_sel;
    logic [3:0] w_alu_op;

    assign w_is_jr = (bus.op == c_OP_RTYPE) && (bus.funct == c_F_JR);
    assign w_is_lw = (bus.op == c_OP_LW);
    assign w_is_sw = (bus.op == c_OP_SW);

    // Instruction decode: legality plus the EXE-phase ALU operation
    always_comb begin
        w_valid     = 1'b0;
        w_shamt     = 1'b0;
        w_itype_alu = 1'b0;
        w_ext_zero  = 1'b0;
        w_alu_code  = c_ALU_ADD;
        if (bus.op == c_OP_RTYPE) begin
            case (bus.funct)
                c_F_ADD, c_F_ADDU: begin w_valid = 1'b1; w_alu_code = c_ALU_ADD;  end
                c_F_SUB, c_F_SUBU: begin w_valid = 1'b1; w_alu_code = c_ALU_SUB;  end
                c_F_AND:           begin w_valid = 1'b1; w_alu_code = c_ALU_AND;  end
                c_F_OR:            begin w_valid = 1'b1; w_alu_code = c_ALU_OR;   end
                c_F_NOR:           begin w_valid = 1'b1; w_alu_code = c_ALU_NOR;  end
                c_F_SLT:           begin w_valid = 1'b1; w_alu_code = c_ALU_SLT;  end
                c_F_SLTU:          begin w_valid = 1'b1; w_alu_code = c_ALU_SLTU; end
                c_F_SLL:  begin w_valid = 1'b1; w_shamt = 1'b1; w_alu_code = c_ALU_SLL; end
                c_F_SRL:  begin w_valid = 1'b1; w_shamt = 1'b1; w_alu_code = c_ALU_SRL; end
                c_F_SLLV:          begin w_valid = 1'b1; w_alu_code = c_ALU_SLL;  end
                c_F_SRLV:          begin w_valid = 1'b1; w_alu_code = c_ALU_SRL;  end
                c_F_JR:            begin w_valid = 1'b1; end
                default: ;
            endcase
        end else begin
            case (bus.op)
                c_OP_ADDI: begin w_valid = 1'b1; w_itype_alu = 1'b1; w_alu_code = c_ALU_ADD; end
                c_OP_SLTI: begin w_valid = 1'b1; w_itype_alu = 1'b1; w_alu_code = c_ALU_SLT; end
                c_OP_LUI:  begin w_valid = 1'b1; w_itype_alu = 1'b1; w_alu_code = c_ALU_LUI; end
                c_OP_ANDI: begin
                    w_valid = 1'b1; w_itype_alu = 1'b1; w_ext_zero = 1'b1; w_alu_code = c_ALU_AND;
                end
                c_OP_ORI:  begin
                    w_valid = 1'b1; w_itype_alu = 1'b1; w_ext_zero = 1'b1; w_alu_code = c_ALU_OR;
                end
                c_OP_LW, c_OP_SW:   begin w_valid = 1'b1; w_alu_code = c_ALU_ADD; end
                c_OP_BEQ, c_OP_BNE: begin w_valid = 1'b1; w_alu_code = c_ALU_SUB; end
                c_OP_J, c_OP_JAL:   begin w_valid = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_trap_code_nxt = 2'b00;
        w_mem_req       = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_write     = 1'b0;
        w_pc_write      = 1'b0;
        w_ir_write      = 1'b0;
        w_ext_op        = 1'b1;
        w_iord          = 1'b0;
        w_alu_src_a     = 2'd1;
        w_alu_src_b     = 2'd0;
        w_pc_source     = 2'd0;
        w_gpr_sel       = 2'd0;
        w_wd_sel        = 2'd0;
        w_alu_op        = c_ALU_ADD;
        case (r_state)
            S_IF: begin
                w_mem_req   = 1'b1;
                w_alu_src_a = 2'd0;
                w_alu_src_b = 2'd1;
                if (bus.mem_ready) begin
                    w_pc_write  = 1'b1;
                    w_ir_write  = 1'b1;
                    w_state_nxt = S_ID;
                end
            end
            S_ID: begin
                if (!w_valid) begin
                    w_state_nxt     = S_TRAP;
                    w_trap_code_nxt = c_TRAP_ILL;
                end else if (bus.op == c_OP_J || bus.op == c_OP_JAL) begin
                    w_pc_source = 2'd2;
                    w_pc_write  = 1'b1;
                    w_state_nxt = S_IF;
                    if (bus.op == c_OP_JAL) begin
                        w_reg_write = 1'b1;
                        w_wd_sel    = 2'd2;
                        w_gpr_sel   = 2'd2;
                    end
                end else if (w_is_jr) begin
                    w_pc_source = 2'd3;
                    w_pc_write  = 1'b1;
                    w_state_nxt = S_IF;
                end else begin
                    // Speculative branch target lands in ALUOut
                    w_alu_src_a = 2'd0;
                    w_alu_src_b = 2'd3;
                    w_state_nxt = S_EXE;
                end
            end
            S_EXE: begin
                w_alu_op = w_alu_code;
                if (bus.op == c_OP_BEQ || bus.op == c_OP_BNE) begin
                    w_pc_source = 2'd1;
                    w_pc_write  = (bus.op == c_OP_BEQ) ? bus.zero : ~bus.zero;
                    w_state_nxt = S_IF;
                end else if (w_is_lw || w_is_sw) begin
                    w_alu_src_b = 2'd2;
                    w_state_nxt = S_MEM;
                end else if (w_shamt) begin
                    w_alu_src_a = 2'd2;
                    w_state_nxt = S_WB;
                end else if (w_itype_alu) begin
                    w_alu_src_b = 2'd2;
                    w_ext_op    = ~w_ext_zero;
                    w_state_nxt = S_WB;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                w_iord      = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_write = w_is_sw;
                if (bus.mem_ready) begin
                    w_state_nxt = w_is_sw ? S_IF : S_WB;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_wd_sel    = w_is_lw ? 2'd1 : 2'd0;
                w_gpr_sel   = (w_is_lw || w_itype_alu) ? 2'd1 : 2'd0;
                w_state_nxt = S_IF;
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = S_IF;
            end
        endcase
        if (w_tmo_hit) begin
            w_state_nxt     = S_TRAP;
            w_trap_code_nxt = c_TRAP_TMO;
        end
    end

    generate
        if (TMO_CYC > 0) begin : g_wdog
            localparam int c_TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
            localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TMO_CYC - 1);
            logic               w_wait;
            logic [c_TMO_W-1:0] r_tmo;

            assign w_wait    = ((r_state == S_IF) || (r_state == S_MEM)) && !bus.mem_ready;
            // Fires on the TMO_CYC-th consecutive unanswered request cycle
            assign w_tmo_hit = w_wait && (r_tmo == c_TMO_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tmo <= '0;
                end else if (!w_wait || (w_state_nxt != r_state)) begin
                    r_tmo <= '0;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end
        end else begin : g_no_wdog
            assign w_tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trap      <= 1'b0;
            r_trap_code <= 2'b00;
        end else if ((r_state != S_TRAP) && (w_state_nxt == S_TRAP)) begin
            r_trap      <= 1'b1;
            r_trap_code <= w_trap_code_nxt;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_inst_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else if (r_state != S_TRAP) begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if ((r_state != S_IF) && (w_state_nxt == S_IF)) begin
                r_inst_cnt <= r_inst_cnt + 1'b1;
            end
        end
    end

    assign cyc_cnt  = r_cyc_cnt;
    assign inst_cnt = r_inst_cnt;
`endif

    // Strobes are forced low for the whole time reset is asserted
    assign bus.mem_req   = w_mem_req   & ~rst;
    assign bus.reg_write = w_reg_write & ~rst;
    assign bus.mem_write = w_mem_write & ~rst;
    assign bus.pc_write  = w_pc_write  & ~rst;
    assign bus.ir_write  = w_ir_write  & ~rst;
    assign bus.ext_op    = w_ext_op;
    assign bus.iord      = w_iord;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.pc_source = w_pc_source;
    assign bus.gpr_sel   = w_gpr_sel;
    assign bus.wd_sel    = w_wd_sel;
    assign bus.alu_op    = ALUOP_W'(w_alu_op);
    assign bus.trap      = r_trap;
    assign bus.trap_code = r_trap_code;
    assign bus.state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_hs
// Brief    : Directed self-checking bench for mc_ctrl_hs (watchdog at 4 cycles).
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl_hs;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mc_ctrl_hs_if #(.ALUOP_W(4)) bus ();

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] inst_cnt;
    mc_ctrl_hs #(.ALUOP_W(4), .TMO_CYC(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus.master), .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
    );
`else
    mc_ctrl_hs #(.ALUOP_W(4), .TMO_CYC(4)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] funct);
        bus.op    = op;
        bus.funct = funct;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.zero = 1'b0;
        bus.op = 6'h00;
        bus.funct = 6'h00;
        bus.mem_ready = 1'b1;
        step(2);

        // Reset state: strobes held low even with mem_ready high
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_trap", 32'(bus.trap), 32'd0);
        chk("rst_code", 32'(bus.trap_code), 32'd0);
        chk("rst_strobes", 32'({bus.mem_req, bus.pc_write, bus.ir_write}), 32'd0);
        rst = 1'b0;
        #1;

        // add
        instr(6'h00, 6'h20);
        chk("if_strobes", 32'({bus.mem_req, bus.pc_write, bus.ir_write}), 32'b111);
        chk("if_src", 32'({bus.alu_src_a, bus.alu_src_b}), 32'b0001);
        step(1);
        chk("add_id_state", 32'(bus.state_o), 32'd1);
        chk("add_id_srcb", 32'(bus.alu_src_b), 32'd3);
        step(1);
        chk("add_exe_state", 32'(bus.state_o), 32'd2);
        chk("add_exe_aluop", 32'(bus.alu_op), 32'd1);
        chk("add_exe_regw", 32'(bus.reg_write), 32'd0);
        step(1);
        chk("add_wb_state", 32'(bus.state_o), 32'd4);
        chk("add_wb_regw", 32'(bus.reg_write), 32'd1);
        chk("add_wb_sel", 32'({bus.gpr_sel, bus.wd_sel}), 32'd0);
        step(1);
        chk("add_back_if", 32'(bus.state_o), 32'd0);

        // lw with three wait cycles
        instr(6'h23, 6'h00);
        step(1);
        bus.mem_ready = 1'b0;
        step(1);
        chk("lw_exe_srcb", 32'(bus.alu_src_b), 32'd2);
        step(1);
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait", 32'({bus.state_o, bus.iord, bus.mem_req, bus.mem_write}), 32'b011110);
            step(1);
        end
        bus.mem_ready = 1'b1;
        chk("lw_mem_last", 32'({bus.state_o, bus.iord}), 32'b0111);
        step(1);
        chk("lw_wb_state", 32'(bus.state_o), 32'd4);
        chk("lw_wb_sel", 32'({bus.wd_sel, bus.gpr_sel, bus.reg_write}), 32'b01011);
        step(1);

        // sw, zero-wait
        instr(6'h2B, 6'h00);
        step(3);
        chk("sw_mem", 32'({bus.state_o, bus.mem_write, bus.iord}), 32'b01111);
        step(1);
        chk("sw_back_if", 32'(bus.state_o), 32'd0);

        // beq taken / not taken
        instr(6'h04, 6'h00);
        bus.zero = 1'b1;
        step(2);
        chk("beq_t_exe", 32'({bus.pc_write, bus.pc_source, bus.alu_op}), 32'b1010010);
        step(1);
        chk("beq_t_if", 32'(bus.state_o), 32'd0);
        bus.zero = 1'b0;
        step(2);
        chk("beq_nt_exe", 32'({bus.pc_write, bus.pc_source}), 32'b001);
        step(1);
        chk("beq_nt_if", 32'(bus.state_o), 32'd0);

        // bne not taken when zero=1
        instr(6'h05, 6'h00);
        bus.zero = 1'b1;
        step(2);
        chk("bne_exe", 32'(bus.pc_write), 32'd0);
        step(1);

        // ori: zero-extended immediate
        instr(6'h0D, 6'h00);
        step(2);
        chk("ori_exe", 32'({bus.ext_op, bus.alu_src_b, bus.alu_op}), 32'b0100100);
        step(1);
        chk("ori_wb", 32'({bus.gpr_sel, bus.wd_sel}), 32'b0100);
        step(1);

        // sll uses shamt
        instr(6'h00, 6'h00);
        step(2);
        chk("sll_exe", 32'({bus.alu_src_a, bus.alu_op}), 32'b100111);
        step(2);

        // j, jal, jr complete in ID
        instr(6'h02, 6'h00);
        step(1);
        chk("j_id", 32'({bus.pc_write, bus.pc_source, bus.reg_write}), 32'b1100);
        step(1);
        chk("j_back_if", 32'(bus.state_o), 32'd0);
        instr(6'h03, 6'h00);
        step(1);
        chk("jal_id", 32'({bus.reg_write, bus.wd_sel, bus.gpr_sel}), 32'b11010);
        step(1);
        instr(6'h00, 6'h08);
        step(1);
        chk("jr_id", 32'({bus.pc_write, bus.pc_source}), 32'b111);
        step(1);

        // Asynchronous reset mid-MEM aborts the access
        instr(6'h23, 6'h00);
        step(2);
        bus.mem_ready = 1'b0;
        step(1);
        chk("abort_pre", 32'(bus.state_o), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_state", 32'(bus.state_o), 32'd0);
        chk("abort_memreq", 32'(bus.mem_req), 32'd0);
        step(1);
        rst = 1'b0;
        #1;

        // Watchdog: mem_ready held low in IF
        step(3);
        chk("tmo_pre", 32'({bus.state_o, bus.trap, bus.mem_req}), 32'b00001);
        step(1);
        chk("tmo_state", 32'(bus.state_o), 32'd7);
        chk("tmo_trap", 32'({bus.trap, bus.trap_code}), 32'b110);
        chk("tmo_memreq", 32'(bus.mem_req), 32'd0);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        chk("rst2_clear", 32'({bus.state_o, bus.trap, bus.trap_code}), 32'd0);

        // Illegal opcode
        bus.mem_ready = 1'b1;
        instr(6'h3F, 6'h00);
        step(1);
        chk("ill_id", 32'({bus.state_o, bus.pc_write, bus.reg_write, bus.ir_write}), 32'b001000);
        step(1);
        chk("ill_trap", 32'({bus.state_o, bus.trap, bus.trap_code}), 32'b111101);
        instr(6'h04, 6'h00);
        bus.zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ill_quiet", 32'({bus.mem_req, bus.pc_write, bus.ir_write, bus.reg_write,
                                 bus.mem_write, bus.trap}), 32'b000001);
            step(1);
        end

        // Illegal R-type funct
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        instr(6'h00, 6'h3F);
        step(2);
        chk("ill_funct", 32'({bus.state_o, bus.trap_code}), 32'b11101);

`ifdef MC_CTRL_PERF_EN
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        #1;
        chk("perf_rst", cyc_cnt | inst_cnt, 32'd0);
        instr(6'h08, 6'h00);
        step(12);
        chk("perf_inst", inst_cnt, 32'd3);
        chk("perf_cyc", cyc_cnt, 32'd12);
        instr(6'h23, 6'h00);
        bus.mem_ready = 1'b1;
        step(3);
        bus.mem_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("perf_abort", 32'(bus.state_o), 32'd0);
        chk("perf_abort_cnt", cyc_cnt | inst_cnt, 32'd0);
        step(1);
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
